// File: rtl/ma_stage.sv
// ma_stage: memory-access stage owning the data RAM; steers store byte lanes, extracts/extends load data.
// Latency: 1 cycle MA->WB for loads and ALU results; load lane select/extension is combinational after the WB regs.
// Backpressure: stall freezes all registers and gates RAM enables; rst_pipe flushes WB state even while stalled.
//
// Optional feature macro: MA_IO_PORT_EN -- one 32-bit IO register decoded at IO_BASE, exposed on io_wdata.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_ld_ma/cmd_st_ma   load / store in MA
//   rd_adr_ma             destination register
//   rd_data_ma            ALU result: effective address for ld/st, else writeback data
//   wbk_rd_reg_ma         writeback enable
//   st_data_ma            low-justified store data
//   ldst_code_ma          funct3: [1:0] 00=B 01=H 1x=W, [2]=1 unsigned load
//   stall, rst_pipe       hold all state / synchronous flush
//   rd_adr_wb, wbk_rd_reg_wb, wbk_data_wb   regfile write port (wbk_data_wb is forwarding source 1)
//   wbk_data_wb2          wbk_data_wb one cycle older (forwarding source 2)
//   misalign_ma           combinational misalignment flag for the ld/st currently in MA
//   io_wdata              IO register value (only with MA_IO_PORT_EN)
module ma_stage #(
  parameter int unsigned DMEM_AW = 12,
  parameter logic [31:0] IO_BASE = 32'hC000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_ld_ma,
  input  logic        cmd_st_ma,
  input  logic [4:0]  rd_adr_ma,
  input  logic [31:0] rd_data_ma,
  input  logic        wbk_rd_reg_ma,
  input  logic [31:0] st_data_ma,
  input  logic [2:0]  ldst_code_ma,
  input  logic        stall,
  input  logic        rst_pipe,
  output logic [4:0]  rd_adr_wb,
  output logic        wbk_rd_reg_wb,
  output logic [31:0] wbk_data_wb,
  output logic [31:0] wbk_data_wb2,
  output logic        misalign_ma
`ifdef MA_IO_PORT_EN
  ,
  output logic [31:0] io_wdata
`endif
);

  localparam int unsigned DEPTH = 1 << DMEM_AW;

  // ---------------------------------------------------------------------------
  // MA-side decode
  // ---------------------------------------------------------------------------
  logic [DMEM_AW-1:0] w_idx;
  logic [1:0]         w_ofs;
  logic               w_is_h;
  logic               w_is_w;
  logic               w_io_hit;
  logic               w_st_go;
  logic               w_ram_we;
  logic               w_ram_re;
  logic [3:0]         w_be;
  logic [31:0]        w_st_dat;

  // Upper address bits above the RAM are ignored, so addresses alias (wrap).
  assign w_idx  = rd_data_ma[DMEM_AW+1:2];
  assign w_ofs  = rd_data_ma[1:0];
  // Codes 3'b011/3'b111 fall into the word class through bit 1.
  assign w_is_w = ldst_code_ma[1];
  assign w_is_h = (ldst_code_ma[1:0] == 2'b01);

  assign misalign_ma = (cmd_ld_ma | cmd_st_ma) &
                       ((w_is_h & w_ofs[0]) | (w_is_w & (w_ofs != 2'b00)));

`ifdef MA_IO_PORT_EN
  assign w_io_hit = (rd_data_ma[31:2] == IO_BASE[31:2]);
`else
  logic [31:0] w_unused_io;
  assign w_io_hit    = 1'b0;
  assign w_unused_io = IO_BASE;
`endif

  // A misaligned store is dropped entirely; misaligned loads still read.
  assign w_st_go  = cmd_st_ma & ~stall & ~misalign_ma;
  assign w_ram_we = w_st_go & ~w_io_hit;
  assign w_ram_re = cmd_ld_ma & ~stall & ~w_io_hit;

  // Store steering: replicate the narrow datum across the word so the byte
  // enables alone pick the destination lane.
  always_comb begin
    w_be     = 4'b0000;
    w_st_dat = st_data_ma;
    if (w_is_w) begin
      w_be     = 4'b1111;
    end else if (w_is_h) begin
      w_be     = 4'b0011 << {w_ofs[1], 1'b0};
      w_st_dat = {2{st_data_ma[15:0]}};
    end else begin
      w_be     = 4'b0001 << w_ofs;
      w_st_dat = {4{st_data_ma[7:0]}};
    end
  end

  // ---------------------------------------------------------------------------
  // Data RAM: synchronous write with byte enables, registered read.
  // The read register only moves on a load, so it holds through stalls and
  // through later stores to the same word.
  // ---------------------------------------------------------------------------
  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_ram_q;

  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_st_dat[8*i +: 8];
        end
      end
    end
    if (w_ram_re) begin
      r_ram_q <= r_mem[w_idx];
    end
  end

  // ---------------------------------------------------------------------------
  // Optional IO register; loads from it use the same one-cycle path as RAM.
  // ---------------------------------------------------------------------------
  logic [31:0] w_ld_q;

`ifdef MA_IO_PORT_EN
  logic [31:0] r_io_wdata;
  logic [31:0] r_io_q;
  logic        r_io_sel_wb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_io_wdata <= '0;
    end else if (rst_pipe) begin
      r_io_wdata <= '0;
    end else if (w_st_go & w_io_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_io_wdata[8*i +: 8] <= w_st_dat[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cmd_ld_ma & ~stall & w_io_hit) begin
      r_io_q <= r_io_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_io_sel_wb <= 1'b0;
    end else if (rst_pipe) begin
      r_io_sel_wb <= 1'b0;
    end else if (!stall) begin
      r_io_sel_wb <= w_io_hit;
    end
  end

  assign io_wdata = r_io_wdata;
  assign w_ld_q   = r_io_sel_wb ? r_io_q : r_ram_q;
`else
  assign w_ld_q   = r_ram_q;
`endif

  // ---------------------------------------------------------------------------
  // MA -> WB pipeline registers
  // ---------------------------------------------------------------------------
  logic        r_ld_wb;
  logic [2:0]  r_code_wb;
  logic [1:0]  r_ofs_wb;
  logic [31:0] r_alu_wb;
  logic [4:0]  r_rd_adr_wb;
  logic        r_wbk_rd_reg_wb;
  logic [31:0] r_wbk_data_wb2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ld_wb         <= 1'b0;
      r_code_wb       <= '0;
      r_ofs_wb        <= '0;
      r_alu_wb        <= '0;
      r_rd_adr_wb     <= '0;
      r_wbk_rd_reg_wb <= 1'b0;
      r_wbk_data_wb2  <= '0;
    end else if (rst_pipe) begin
      // Flush wins over stall so a squashed load cannot linger in WB.
      r_ld_wb         <= 1'b0;
      r_code_wb       <= '0;
      r_ofs_wb        <= '0;
      r_alu_wb        <= '0;
      r_rd_adr_wb     <= '0;
      r_wbk_rd_reg_wb <= 1'b0;
      r_wbk_data_wb2  <= '0;
    end else if (!stall) begin
      r_ld_wb         <= cmd_ld_ma;
      r_code_wb       <= ldst_code_ma;
      r_ofs_wb        <= w_ofs;
      r_alu_wb        <= rd_data_ma;
      r_rd_adr_wb     <= rd_adr_ma;
      r_wbk_rd_reg_wb <= wbk_rd_reg_ma & (rd_adr_ma != 5'd0);
      r_wbk_data_wb2  <= wbk_data_wb;
    end
  end

  // ---------------------------------------------------------------------------
  // WB load extraction. Misaligned loads take the aligned-down lane: halves
  // use only ofs[1], words ignore the offset altogether.
  // ---------------------------------------------------------------------------
  logic [7:0]  w_lane_b;
  logic [15:0] w_lane_h;
  logic [31:0] w_ld_ext;

  always_comb begin
    w_lane_b = w_ld_q[7:0];
    case (r_ofs_wb)
      2'd0:    w_lane_b = w_ld_q[7:0];
      2'd1:    w_lane_b = w_ld_q[15:8];
      2'd2:    w_lane_b = w_ld_q[23:16];
      default: w_lane_b = w_ld_q[31:24];
    endcase
    w_lane_h = r_ofs_wb[1] ? w_ld_q[31:16] : w_ld_q[15:0];
    w_ld_ext = w_ld_q;
    if (!r_code_wb[1]) begin
      if (r_code_wb[0]) begin
        w_ld_ext = {{16{~r_code_wb[2] & w_lane_h[15]}}, w_lane_h};
      end else begin
        w_ld_ext = {{24{~r_code_wb[2] & w_lane_b[7]}}, w_lane_b};
      end
    end
  end

  assign wbk_data_wb   = r_ld_wb ? w_ld_ext : r_alu_wb;
  assign wbk_data_wb2  = r_wbk_data_wb2;
  assign rd_adr_wb     = r_rd_adr_wb;
  assign wbk_rd_reg_wb = r_wbk_rd_reg_wb;

endmodule

// File: tb/tb_ma_stage.sv
// tb_ma_stage: drives ma_stage with directed and random ld/st/ALU traffic and
// compares every cycle against a byte-addressed behavioural memory model.
module tb_ma_stage;
  localparam logic [31:0] IO_BASE = 32'hC000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_ld_ma = 1'b0;
  logic        cmd_st_ma = 1'b0;
  logic [4:0]  rd_adr_ma = '0;
  logic [31:0] rd_data_ma = '0;
  logic        wbk_rd_reg_ma = 1'b0;
  logic [31:0] st_data_ma = '0;
  logic [2:0]  ldst_code_ma = '0;
  logic        stall = 1'b0;
  logic        rst_pipe = 1'b0;
  logic [4:0]  rd_adr_wb;
  logic        wbk_rd_reg_wb;
  logic [31:0] wbk_data_wb;
  logic [31:0] wbk_data_wb2;
  logic        misalign_ma;
`ifdef MA_IO_PORT_EN
  logic [31:0] io_wdata;
`endif

  ma_stage #(.DMEM_AW(12), .IO_BASE(IO_BASE)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_ld_ma     (cmd_ld_ma),
    .cmd_st_ma     (cmd_st_ma),
    .rd_adr_ma     (rd_adr_ma),
    .rd_data_ma    (rd_data_ma),
    .wbk_rd_reg_ma (wbk_rd_reg_ma),
    .st_data_ma    (st_data_ma),
    .ldst_code_ma  (ldst_code_ma),
    .stall         (stall),
    .rst_pipe      (rst_pipe),
    .rd_adr_wb     (rd_adr_wb),
    .wbk_rd_reg_wb (wbk_rd_reg_wb),
    .wbk_data_wb   (wbk_data_wb),
    .wbk_data_wb2  (wbk_data_wb2),
    .misalign_ma   (misalign_ma)
`ifdef MA_IO_PORT_EN
    ,
    .io_wdata      (io_wdata)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: byte-addressed memory image (14-bit byte address space)
  // ---------------------------------------------------------------------------
  logic [7:0]  m_b [0:16383];
  logic [31:0] m_io = '0;
  logic [31:0] e_data = '0;
  logic [31:0] e_data2 = '0;
  logic [4:0]  e_adr = '0;
  logic        e_we = 1'b0;

  function automatic int sz_of(input logic [2:0] code);
    if (code[1]) return 4;
    if (code[0]) return 2;
    return 1;
  endfunction

  function automatic logic is_io(input logic [31:0] a);
`ifdef MA_IO_PORT_EN
    return a[31:2] == IO_BASE[31:2];
`else
    return (a != a);
`endif
  endfunction

  function automatic logic misal(input logic ld, input logic st, input logic [2:0] code,
                                 input logic [31:0] a);
    return (ld || st) && ((int'(a[1:0]) % sz_of(code)) != 0);
  endfunction

  // Value a load returns: bytes from the aligned-down address, then extended.
  function automatic logic [31:0] read_val(input logic [31:0] a, input logic [2:0] code);
    int n = sz_of(code);
    int base = int'(a[13:0]) - (int'(a[1:0]) % n);
    logic [31:0] v = '0;
    for (int k = 0; k < n; k++) begin
      logic [7:0] b;
      if (is_io(a)) b = m_io[8*((base + k) % 4) +: 8];
      else          b = m_b[base + k];
      v = v | ({24'b0, b} << (8 * k));
    end
    if (!code[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic write_val(input logic [31:0] a, input logic [2:0] code, input logic [31:0] d);
    int n = sz_of(code);
    int base = int'(a[13:0]);
    for (int k = 0; k < n; k++) begin
      if (is_io(a)) m_io[8*((base + k) % 4) +: 8] = d[8*k +: 8];
      else          m_b[base + k] = d[8*k +: 8];
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) m_b[i] = 8'h00;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        e_data = '0; e_data2 = '0; e_adr = '0; e_we = 1'b0; m_io = '0;
      end else begin
        if (rst_pipe) begin
          e_data = '0; e_data2 = '0; e_adr = '0; e_we = 1'b0; m_io = '0;
        end else if (!stall) begin
          e_data2 = e_data;
          e_data  = cmd_ld_ma ? read_val(rd_data_ma, ldst_code_ma) : rd_data_ma;
          e_adr   = rd_adr_ma;
          e_we    = wbk_rd_reg_ma && (rd_adr_ma != 5'd0);
        end
        if (!stall && cmd_st_ma && !misal(cmd_ld_ma, cmd_st_ma, ldst_code_ma, rd_data_ma) &&
            !(rst_pipe && is_io(rd_data_ma)))
          write_val(rd_data_ma, ldst_code_ma, st_data_ma);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("wbk_data_wb", wbk_data_wb, e_data);
        chk("wbk_data_wb2", wbk_data_wb2, e_data2);
        chk("rd_adr_wb", {27'b0, rd_adr_wb}, {27'b0, e_adr});
        chk("wbk_rd_reg_wb", {31'b0, wbk_rd_reg_wb}, {31'b0, e_we});
        chk("misalign_ma", {31'b0, misalign_ma},
            {31'b0, misal(cmd_ld_ma, cmd_st_ma, ldst_code_ma, rd_data_ma)});
`ifdef MA_IO_PORT_EN
        chk("io_wdata", io_wdata, m_io);
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic drive(input logic ld, input logic st, input logic [4:0] adr,
                       input logic [31:0] dat, input logic wbk, input logic [31:0] sd,
                       input logic [2:0] code, input logic stl, input logic rp);
    @(posedge clk);
    #2;
    cmd_ld_ma = ld; cmd_st_ma = st; rd_adr_ma = adr; rd_data_ma = dat;
    wbk_rd_reg_ma = wbk; st_data_ma = sd; ldst_code_ma = code; stall = stl; rst_pipe = rp;
  endtask

  task automatic nop();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 3'b000, 1'b0, 1'b0);
  endtask

  task automatic st_op(input logic [31:0] a, input logic [31:0] d, input logic [2:0] code);
    drive(1'b0, 1'b1, 5'd0, a, 1'b0, d, code, 1'b0, 1'b0);
  endtask

  task automatic ld_op(input logic [4:0] rd, input logic [31:0] a, input logic [2:0] code);
    drive(1'b1, 1'b0, rd, a, 1'b1, 32'd0, code, 1'b0, 1'b0);
  endtask

  // Issue a load, let it reach WB, and check the written-back value.
  task automatic ld_chk(input string name, input logic [31:0] a, input logic [2:0] code,
                        input logic [31:0] exp);
    ld_op(5'd3, a, code);
    nop();
    @(negedge clk);
    chk(name, wbk_data_wb, exp);
  endtask

  initial begin
    logic [31:0] a;
    logic        ld;
    logic        st;
    int          r;

    repeat (3) nop();
    @(negedge clk);
    chk("rst_wbk_data_wb", wbk_data_wb, 32'h0);
    chk("rst_wbk_rd_reg_wb", {31'b0, wbk_rd_reg_wb}, 32'h0);
    chk("rst_rd_adr_wb", {27'b0, rd_adr_wb}, 32'h0);
    chk("rst_wbk_data_wb2", wbk_data_wb2, 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Fill a 256-word window so every later load reads defined data.
    for (int w = 0; w < 256; w++) st_op(32'(w * 4), $urandom, 3'b010);

    st_op(32'h100, 32'hDEAD_BEEF, 3'b010);
    ld_chk("lw_deadbeef", 32'h100, 3'b010, 32'hDEAD_BEEF);
    chk("lw_rd_adr", {27'b0, rd_adr_wb}, 32'd3);
    chk("lw_we", {31'b0, wbk_rd_reg_wb}, 32'd1);

    st_op(32'h200, 32'h1122_3344, 3'b010);
    st_op(32'h203, 32'h1234_5680, 3'b000);
    ld_chk("lb_sign", 32'h203, 3'b000, 32'hFFFF_FF80);
    ld_chk("lbu_zero", 32'h203, 3'b100, 32'h0000_0080);
    ld_chk("sb_other_bytes", 32'h200, 3'b010, 32'h8022_3344);
    ld_chk("code011_is_w", 32'h200, 3'b011, 32'h8022_3344);
    ld_chk("code111_is_w", 32'h200, 3'b111, 32'h8022_3344);

    st_op(32'h102, 32'hFFFF_1234, 3'b001);
    ld_chk("sh_upper", 32'h100, 3'b010, 32'h1234_BEEF);
    st_op(32'h101, 32'h0000_5555, 3'b001);
    @(negedge clk);
    chk("sh_misalign_flag", {31'b0, misalign_ma}, 32'd1);
    ld_chk("sh_misalign_no_write", 32'h100, 3'b010, 32'h1234_BEEF);

    ld_chk("lh_misalign_lane", 32'h103, 3'b001, 32'h0000_1234);
    ld_chk("lh_sign", 32'h101, 3'b001, 32'hFFFF_BEEF);
    ld_chk("lhu_zero", 32'h101, 3'b101, 32'h0000_BEEF);
    ld_chk("lw_misalign", 32'h102, 3'b010, 32'h1234_BEEF);
    ld_chk("lw_wrap", 32'h4000_4100, 3'b010, 32'h1234_BEEF);

    // Load in WB held by a 3-cycle stall, then flushed while still stalled.
    ld_op(5'd7, 32'h100, 3'b010);
    drive(1'b1, 1'b0, 5'd9, 32'h204, 1'b1, 32'd0, 3'b010, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("stall_data", wbk_data_wb, 32'h1234_BEEF);
      chk("stall_adr", {27'b0, rd_adr_wb}, 32'd7);
      chk("stall_we", {31'b0, wbk_rd_reg_wb}, 32'd1);
    end
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 3'b000, 1'b1, 1'b1);
    @(negedge clk);
    chk("stall_data_last", wbk_data_wb, 32'h1234_BEEF);
    nop();
    @(negedge clk);
    chk("flush_in_stall_we", {31'b0, wbk_rd_reg_wb}, 32'd0);

    // Store in MA while the load to the same word sits in WB; then RAW.
    ld_op(5'd4, 32'h100, 3'b010);
    st_op(32'h100, 32'hCAFE_F00D, 3'b010);
    @(negedge clk);
    chk("wb_pre_store", wbk_data_wb, 32'h1234_BEEF);
    ld_chk("raw_post_store", 32'h100, 3'b010, 32'hCAFE_F00D);

    drive(1'b0, 1'b0, 5'd5, 32'h55, 1'b1, 32'd0, 3'b000, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 5'd6, 32'h66, 1'b1, 32'd0, 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    chk("alu_0x55", wbk_data_wb, 32'h55);
    drive(1'b0, 1'b0, 5'd0, 32'h77, 1'b1, 32'd0, 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    chk("alu_0x66", wbk_data_wb, 32'h66);
    chk("alu_wb2_0x55", wbk_data_wb2, 32'h55);
    nop();
    @(negedge clk);
    chk("rd0_no_write", {31'b0, wbk_rd_reg_wb}, 32'd0);

`ifdef MA_IO_PORT_EN
    st_op(IO_BASE, 32'hA5A5_A5A5, 3'b010);
    nop();
    @(negedge clk);
    chk("io_wdata_sw", io_wdata, 32'hA5A5_A5A5);
    ld_chk("io_lw", IO_BASE, 3'b010, 32'hA5A5_A5A5);
    ld_chk("io_ram_untouched", 32'h0, 3'b010, read_val(32'h0, 3'b010));
`endif

    // Random traffic over the initialised window with aliased upper bits.
    for (int c = 0; c < 3000; c++) begin
      r  = $urandom_range(0, 99);
      ld = (r < 30);
      st = (r >= 30) && (r < 60);
      if (ld || st) a = {14'($urandom), 4'b0000, 10'($urandom), 4'b0000} >> 4;
      else          a = $urandom;
      if (ld || st) a = {a[31:14], 4'b0000, a[9:0]};
`ifdef MA_IO_PORT_EN
      if ((ld || st) && $urandom_range(0, 19) == 0) a = IO_BASE | 32'($urandom_range(0, 3));
`endif
      drive(ld, st, 5'($urandom), a, 1'($urandom), $urandom, 3'($urandom),
            $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0);
      if (c == 1500) begin
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        @(negedge clk);
        chk("async_rst_we", {31'b0, wbk_rd_reg_wb}, 32'd0);
        chk("async_rst_data", wbk_data_wb, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
      end
    end
    nop();
    nop();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
